// File: rtl/gate_op_stage_if.sv
// rtl/gate_op_stage_if.sv - operand-issue and result-delivery handshake bundle for gate_op_stage
//
// Signals:
//   in_valid/in_ready   operand beat handshake (upstream -> stage)
//   in_a, in_b, in_op   operands and 3-bit opcode
//   out_valid/out_ready result beat handshake (stage -> downstream)
//   out_c, out_err      result and illegal-opcode tag
// Modports: master = producer/consumer side, slave = the stage itself.
interface gate_op_stage_if #(
    parameter int N = 3
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_a;
    logic [N-1:0] in_b;
    logic [2:0]   in_op;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_c;
    logic         out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_c, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_c, out_err
    );
endinterface

// File: rtl/gate_op_stage.sv
// rtl/gate_op_stage.sv - two-register operand-issue / result-capture stage around an N-bit gate bank
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   io         gate_op_stage_if.slave: operand handshake in, result handshake out
//   err_flag   sticky flag, set when a result tagged out_err is handed off
//   clr_err    synchronous clear of err_flag (a same-cycle set wins)
//   res_count  count of completed result handshakes, wraps modulo 2^CNT_W
module gate_op_stage #(
    parameter int N     = 3,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    gate_op_stage_if.slave   io,
    output logic             err_flag,
    input  logic             clr_err,
    output logic [CNT_W-1:0] res_count
);
    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_NAND = 3'd2;
    localparam logic [2:0] OP_NOR  = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_XNOR = 3'd5;
    localparam logic [2:0] OP_NOT  = 3'd6;

    // Stage 1: captured operands
    logic         s1_valid;
    logic [N-1:0] s1_a;
    logic [N-1:0] s1_b;
    logic [2:0]   s1_op;

    // Stage 2: registered result, drives the output directly
    logic         s2_valid;
    logic [N-1:0] s2_c;
    logic         s2_err;

    logic         s2_take;
    logic         s1_adv;
    logic         in_fire;
    logic         out_fire;
    logic [N-1:0] gate_c;
    logic         gate_err;

    // Stage 2 frees up either when empty or when its beat leaves this cycle,
    // which lets both registers drain and reload on the same edge.
    assign s2_take     = !s2_valid || io.out_ready;
    assign s1_adv      = s1_valid && s2_take;
    assign io.in_ready = !s1_valid || s2_take;
    assign in_fire     = io.in_valid && io.in_ready;
    assign out_fire    = s2_valid && io.out_ready;

    assign io.out_valid = s2_valid;
    assign io.out_c     = s2_c;
    assign io.out_err   = s2_err;

    // Gate bank; opcode 7 yields a zero result tagged as an error.
    always_comb begin
        gate_c   = '0;
        gate_err = 1'b0;
        case (s1_op)
            OP_AND:  gate_c = s1_a & s1_b;
            OP_OR:   gate_c = s1_a | s1_b;
            OP_NAND: gate_c = ~(s1_a & s1_b);
            OP_NOR:  gate_c = ~(s1_a | s1_b);
            OP_XOR:  gate_c = s1_a ^ s1_b;
            OP_XNOR: gate_c = ~(s1_a ^ s1_b);
            OP_NOT:  gate_c = ~s1_a;
            default: gate_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_a     <= io.in_a;
            s1_b     <= io.in_b;
            s1_op    <= io.in_op;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_c     <= '0;
            s2_err   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            s2_c     <= gate_c;
            s2_err   <= gate_err;
        end else if (out_fire) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_count <= '0;
            err_flag  <= 1'b0;
        end else begin
            if (out_fire) begin
                res_count <= res_count + 1'b1;
            end
            if (out_fire && s2_err) begin
                err_flag <= 1'b1;
            end else if (clr_err) begin
                err_flag <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_gate_op_stage.sv
// tb/tb_gate_op_stage.sv - randomized and directed self-checking bench for gate_op_stage
module tb_gate_op_stage;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr_err;
    logic       err_flag;
    logic [7:0] res_count;
    logic       err_flag2;
    logic [1:0] res_count2;

    int n_checks = 0;
    int n_pass   = 0;

    gate_op_stage_if #(.N(3)) if8 ();
    gate_op_stage_if #(.N(3)) if2 ();

    gate_op_stage #(.N(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .io(if8),
        .err_flag(err_flag), .clr_err(clr_err), .res_count(res_count)
    );

    gate_op_stage #(.N(3), .CNT_W(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .io(if2),
        .err_flag(err_flag2), .clr_err(1'b0), .res_count(res_count2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference gate bank: {err, c}
    function automatic logic [3:0] ref_gate(input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
        case (op)
            3'd0: return {1'b0, a & b};
            3'd1: return {1'b0, a | b};
            3'd2: return {1'b0, ~(a & b)};
            3'd3: return {1'b0, ~(a | b)};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~(a ^ b)};
            3'd6: return {1'b0, ~a};
            default: return 4'b1000;
        endcase
    endfunction

    // Scoreboard on the 8-bit-counter instance, sampled mid-cycle.
    logic [3:0] exp_q[$];
    int         exp_cnt;
    logic       exp_err;
    logic       prev_stall;
    logic [2:0] prev_c;
    logic       prev_e;

    always @(negedge clk) begin
        logic [3:0] e;
        logic       hs;
        if (!rst_n) begin
            exp_q.delete();
            exp_cnt    = 0;
            exp_err    = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("res_count", 32'(res_count), 32'(exp_cnt));
            check("err_flag", 32'(err_flag), 32'(exp_err));
            if (prev_stall) begin
                check("hold_valid", 32'(if8.out_valid), 32'd1);
                check("hold_c", 32'(if8.out_c), 32'(prev_c));
                check("hold_err", 32'(if8.out_err), 32'(prev_e));
            end
            prev_stall = if8.out_valid && !if8.out_ready;
            prev_c     = if8.out_c;
            prev_e     = if8.out_err;
            hs = if8.out_valid && if8.out_ready;
            e  = 4'b0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_c", 32'(if8.out_c), 32'(e[2:0]));
                    check("out_err", 32'(if8.out_err), 32'(e[3]));
                end
                exp_cnt = (exp_cnt + 1) % 256;
            end
            if (hs && e[3]) exp_err = 1'b1;
            else if (clr_err) exp_err = 1'b0;
            if (if8.in_valid && if8.in_ready)
                exp_q.push_back(ref_gate(if8.in_a, if8.in_b, if8.in_op));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic set_in(input logic v, input logic [2:0] a, input logic [2:0] b, input logic [2:0] op);
        if8.in_valid = v;
        if8.in_a     = a;
        if8.in_b     = b;
        if8.in_op    = op;
    endtask

    initial begin
        logic [2:0] tab [7];
        logic [2:0] seq2 [5];
        logic [2:0] got [$];
        int i, k, sent, rcvd, cyc;
        logic hs;

        tab  = '{3'b001, 3'b111, 3'b110, 3'b000, 3'b110, 3'b001, 3'b010};
        seq2 = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
        clr_err = 1'b0;
        set_in(1'b0, 3'd0, 3'd0, 3'd0);
        if8.out_ready = 1'b1;
        if2.in_valid  = 1'b0;
        if2.in_a      = 3'd0;
        if2.in_b      = 3'd0;
        if2.in_op     = 3'd0;
        if2.out_ready = 1'b1;

        // Reset state
        rst_n = 1'b0;
        step();
        check("rst_out_valid", 32'(if8.out_valid), 32'd0);
        check("rst_out_c", 32'(if8.out_c), 32'd0);
        check("rst_out_err", 32'(if8.out_err), 32'd0);
        check("rst_err_flag", 32'(err_flag), 32'd0);
        check("rst_res_count", 32'(res_count), 32'd0);
        check("rst_in_ready", 32'(if8.in_ready), 32'd1);
        check("rst_res_count2", 32'(res_count2), 32'd0);
        step();
        rst_n = 1'b1;

        // Ops 0..6 back to back on a=101, b=011
        for (int j = 0; j < 7; j++) begin
            set_in(1'b1, 3'b101, 3'b011, 3'(j));
            step();
            if (j == 0) check("lat_first", 32'(if8.out_valid), 32'd0);
            else begin
                check("seq_valid", 32'(if8.out_valid), 32'd1);
                check("seq_c", 32'(if8.out_c), 32'(tab[j-1]));
            end
        end
        set_in(1'b0, 3'd0, 3'd0, 3'd0);
        step();
        check("seq_c_last", 32'(if8.out_c), 32'(tab[6]));
        step();
        check("seq_drained", 32'(if8.out_valid), 32'd0);
        check("seq_count", 32'(res_count), 32'd7);

        // Illegal opcode and sticky error flag
        set_in(1'b1, 3'b111, 3'b111, 3'd7);
        step();
        set_in(1'b0, 3'd0, 3'd0, 3'd0);
        step();
        check("op7_valid", 32'(if8.out_valid), 32'd1);
        check("op7_c", 32'(if8.out_c), 32'd0);
        check("op7_err", 32'(if8.out_err), 32'd1);
        step();
        check("op7_flag_set", 32'(err_flag), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("op7_flag_clr", 32'(err_flag), 32'd0);
        set_in(1'b1, 3'b111, 3'b111, 3'd7);
        step();
        set_in(1'b0, 3'd0, 3'd0, 3'd0);
        step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("op7_set_wins", 32'(err_flag), 32'd1);

        // Backpressure: 5 beats offered with out_ready low
        if8.out_ready = 1'b0;
        i = 0;
        for (int c = 0; c < 6; c++) begin
            set_in(1'b1, 3'(i), 3'b111, 3'd0);
            #1;
            if (if8.in_ready) i++;
            step();
        end
        check("bp_accepted", 32'(i), 32'd2);
        check("bp_in_ready", 32'(if8.in_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            check("bp_c_held", 32'(if8.out_c), 32'd0);
            check("bp_valid_held", 32'(if8.out_valid), 32'd1);
            step();
        end
        if8.out_ready = 1'b1;
        got.delete();
        for (int c = 0; c < 20 && got.size() < 5; c++) begin
            set_in(i < 5, 3'(i), 3'b111, 3'd0);
            #1;
            if (if8.in_valid && if8.in_ready) i++;
            if (if8.out_valid && if8.out_ready) got.push_back(if8.out_c);
            step();
        end
        set_in(1'b0, 3'd0, 3'd0, 3'd0);
        check("bp_count", 32'(got.size()), 32'd5);
        for (int j = 0; j < got.size(); j++) check("bp_order", 32'(got[j]), 32'(j));

        // Randomized 1000 beats from a fresh counter
        do_reset();
        sent = 0;
        rcvd = 0;
        cyc  = 0;
        while ((sent < 1000 || rcvd < 1000) && cyc < 20000) begin
            set_in((sent < 1000) && ($urandom_range(0, 3) != 0),
                   3'($urandom), 3'($urandom), 3'($urandom));
            if8.out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (if8.in_valid && if8.in_ready) sent++;
            if (if8.out_valid && if8.out_ready) rcvd++;
            step();
            cyc++;
        end
        set_in(1'b0, 3'd0, 3'd0, 3'd0);
        check("rand_timeout", 32'(cyc < 20000), 32'd1);
        check("rand_res_count", 32'(res_count), 32'd232);

        // Asynchronous reset with two beats in flight
        if8.out_ready = 1'b0;
        set_in(1'b1, 3'd1, 3'b111, 3'd0);
        step();
        step();
        set_in(1'b0, 3'd0, 3'd0, 3'd0);
        check("ar_full", 32'(if8.in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_out_valid", 32'(if8.out_valid), 32'd0);
        check("ar_res_count", 32'(res_count), 32'd0);
        step();
        rst_n = 1'b1;
        check("ar_in_ready", 32'(if8.in_ready), 32'd1);
        if8.out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("ar_no_stale", 32'(if8.out_valid), 32'd0);
        end

        // Counter wrap on the 2-bit-counter instance
        k = 0;
        for (int c = 0; c < 12; c++) begin
            if2.in_valid = (c < 5);
            if2.in_a     = 3'(c);
            if2.in_b     = 3'b111;
            if2.in_op    = 3'd1;
            #1;
            hs = if2.out_valid && if2.out_ready;
            step();
            if (hs && k < 5) begin
                check("wrap_count", 32'(res_count2), 32'(seq2[k]));
                k++;
            end
        end
        if2.in_valid = 1'b0;
        check("wrap_handshakes", 32'(k), 32'd5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
